ctrl_conv_sched: RTL and testbench
==================================

Name: ctrl_conv_sched

Overview:
- Top-level sequencer for one convolution run.
- Owns the shared input AXI-stream. It first steers F_SIZE words into fmem, then steers the stream to the xmem/output controller.
- Issues the single-cycle conv_start once xmem holds F_SIZE words, and counts accepted outputs. On conv_done it checks the output count and re-arms for the next vector.
- Sits between the top-level stream ports and ctrl_xmem_plus_output / fmem.

Parameters:
- X_SIZE, 128, input vector length.
- F_SIZE, 32, filter length; must satisfy 2 <= F_SIZE <= X_SIZE.
- RELOAD_F, 1, 1 = reload the filter before every vector; 0 = filter loaded once after reset, then kept.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- s_valid  in  1  top-level input valid
- s_ready  out  1  top-level input ready (combinational mux)
- fmem_wr_en  out  1  fmem write strobe (= s_valid && s_ready in LOAD_F)
- fmem_addr  out  $clog2(F_SIZE)  fmem write address, registered
- x_s_valid  out  1  valid forwarded to the xmem controller
- x_s_ready  in  1  ready from the xmem controller
- xmem_full  in  1  xmem holds F_SIZE words
- conv_start  out  1  one-cycle start pulse, registered
- conv_done  in  1  one-cycle completion pulse from the xmem controller
- m_valid  in  1  output valid (monitored only)
- m_ready  in  1  output ready (monitored only)
- busy  out  1  high in every state except LOAD_F with fmem_addr==0 and no filter write yet
- y_count_err  out  1  sticky; set on a Y-count mismatch at conv_done

Behaviour:
- Y_SIZE = X_SIZE-F_SIZE+1. y_cnt has width $clog2(Y_SIZE+1) and saturates at Y_SIZE.

Reset values:
- state = LOAD_F.
- fmem_addr = 0, conv_start = 0, y_cnt = 0, y_count_err = 0, f_loaded = 0.

Combinational outputs by state:
- LOAD_F: s_ready = 1, x_s_valid = 0.
- LOAD_X and RUN: s_ready = x_s_ready, x_s_valid = s_valid.
- START and CLR: s_ready = 0, x_s_valid = 0.

State transitions:
- LOAD_F:
  - Each fmem_wr_en writes, then fmem_addr increments.
  - A write at fmem_addr==F_SIZE-1 sets fmem_addr=0 and f_loaded=1 and moves to LOAD_X on the next cycle.
  - No wrap beyond F_SIZE-1.
- LOAD_X:
  - Waits for xmem_full==1, sampled on a clock edge.
  - Then sets conv_start <= 1 and moves to START.
- START:
  - conv_start <= 0; moves to RUN.
  - conv_start is therefore high for exactly one cycle, while the xmem controller is still in its fill state.
- RUN:
  - Input stays routed to xmem, so x loading overlaps with output.
  - Each m_valid && m_ready increments y_cnt.
  - On conv_done==1: if y_cnt (including an accept in the same cycle) != Y_SIZE, set y_count_err=1. Then clear y_cnt and go to CLR.
- CLR:
  - One dead cycle while the xmem controller clears its tracker.
  - Next state: LOAD_F if RELOAD_F==1, else LOAD_X.

Boundary conditions:
- conv_done outside RUN is ignored and does not set y_count_err.
- m_valid && m_ready outside RUN is not counted.
- A handshake in the same cycle as conv_done is counted before the check.
- xmem_full already high on entry to LOAD_X still gives exactly one conv_start pulse, one cycle later.
- reset mid-operation returns to LOAD_F on the next edge, clears the sticky error, and clears f_loaded, so the filter must be reloaded even when RELOAD_F==0.
- s_valid low stalls every counter; there are no implicit writes.

Latency:
- fmem write: same cycle as the handshake.
- conv_start: 1 cycle after xmem_full is sampled high.

Decomposition:
- Package conv_pkg holds:
  - typedef enum sched_state_t {LOAD_F, LOAD_X, START, RUN, CLR};
  - function y_size(x, f) returning x-f+1;
  - shared defaults X_SIZE_DEF and F_SIZE_DEF.
- One natural sub-module: conv_out_counter, holding the saturating y_cnt plus mismatch check (inputs: hs, done, clr; outputs: cnt, err).

Test Plan (X_SIZE=8, F_SIZE=3, Y_SIZE=6 unless noted):
- Filter load, RELOAD_F=1, 3 back-to-back s_valid beats -> fmem_wr_en high 3 cycles with addr 0,1,2; 4th beat is routed to x_s_valid; fmem_wr_en=0.
- x fill: x_s_ready=1, xmem_full rises at cycle T -> conv_start=1 only at T+1; s_ready=0 for the START cycle.
- Full run, 6 output handshakes then conv_done -> y_count_err stays 0; CLR lasts one cycle with s_ready=0; then LOAD_F (fmem_addr=0).
- Short run, conv_done after 5 handshakes -> y_count_err=1 and stays 1 through the next run; reset clears it.
- RELOAD_F=0, two vectors -> second vector skips LOAD_F (no fmem_wr_en); second conv_start after xmem_full.
- Reset during RUN, after 2 outputs -> next cycle state LOAD_F, y_cnt=0, conv_start=0; the next 3 beats write fmem 0..2.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution run sequencer.
package conv_pkg;

  localparam int X_SIZE_DEF = 128;
  localparam int F_SIZE_DEF = 32;

  typedef enum logic [2:0] {
    LOAD_F = 3'd0,
    LOAD_X = 3'd1,
    START  = 3'd2,
    RUN    = 3'd3,
    CLR    = 3'd4
  } sched_state_t;

  function automatic int y_size(input int x, input int f);
    return x - f + 1;
  endfunction

endpackage

// File: rtl/conv_out_counter.sv
// Saturating count of accepted output words, with a sticky mismatch flag
// raised when a run completes with a count other than Y_SIZE.
module conv_out_counter #(
  parameter int Y_SIZE = 97
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         hs,
  input  logic                         done,
  input  logic                         clr,
  output logic [$clog2(Y_SIZE+1)-1:0]  cnt,
  output logic                         err
);

  localparam int CW = $clog2(Y_SIZE + 1);
  localparam logic [CW-1:0] Y_MAX = CW'(Y_SIZE);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_inc_s;
  logic          err_r;
  logic          mismatch_s;

  // Next count including a handshake in the current cycle, and the completion check on it.
  always_comb begin
    cnt_inc_s  = cnt_r;
    mismatch_s = 1'b0;
    if (hs && (cnt_r != Y_MAX)) begin
      cnt_inc_s = cnt_r + CW'(1'b1);
    end else begin
      cnt_inc_s = cnt_r;
    end
    if (done) begin
      mismatch_s = (cnt_inc_s != Y_MAX);
    end else begin
      mismatch_s = 1'b0;
    end
  end

  // Count and sticky error registers; only reset clears the error.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CW{1'b0}};
      err_r <= 1'b0;
    end else begin
      if (clr) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_inc_s;
      end
      if (mismatch_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign cnt = cnt_r;
  assign err = err_r;

endmodule

// File: rtl/ctrl_conv_sched.sv
// Run sequencer: steers the input stream into fmem then xmem, fires conv_start
// once xmem is full, and audits the number of output words per run.
module ctrl_conv_sched
  import conv_pkg::*;
#(
  parameter int X_SIZE   = X_SIZE_DEF,
  parameter int F_SIZE   = F_SIZE_DEF,
  parameter bit RELOAD_F = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic                      fmem_wr_en,
  output logic [$clog2(F_SIZE)-1:0] fmem_addr,
  output logic                      x_s_valid,
  input  logic                      x_s_ready,
  input  logic                      xmem_full,
  output logic                      conv_start,
  input  logic                      conv_done,
  input  logic                      m_valid,
  input  logic                      m_ready,
  output logic                      busy,
  output logic                      y_count_err
);

  localparam int AW     = $clog2(F_SIZE);
  localparam int Y_SIZE = y_size(X_SIZE, F_SIZE);
  localparam int CW     = $clog2(Y_SIZE + 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(F_SIZE - 1);

  sched_state_t  state_r;
  sched_state_t  state_next_s;
  logic [AW-1:0] fmem_addr_r;
  logic [AW-1:0] fmem_addr_next_s;
  logic          conv_start_r;
  logic          conv_start_next_s;
  logic          f_loaded_r;
  logic          f_loaded_next_s;
  logic          wr_s;
  logic          in_run_s;
  logic          hs_s;
  logic          done_s;
  logic [CW-1:0] y_cnt_unused_s;

  // Next-state, stream steering and fmem write address.
  always_comb begin
    state_next_s      = state_r;
    fmem_addr_next_s  = fmem_addr_r;
    conv_start_next_s = 1'b0;
    f_loaded_next_s   = f_loaded_r;
    s_ready           = 1'b0;
    x_s_valid         = 1'b0;
    wr_s              = 1'b0;
    case (state_r)
      LOAD_F: begin
        s_ready = 1'b1;
        wr_s    = s_valid;
        if (s_valid) begin
          if (fmem_addr_r == ADDR_LAST) begin
            fmem_addr_next_s = {AW{1'b0}};
            f_loaded_next_s  = 1'b1;
            state_next_s     = LOAD_X;
          end else begin
            fmem_addr_next_s = fmem_addr_r + AW'(1'b1);
          end
        end else begin
          fmem_addr_next_s = fmem_addr_r;
        end
      end
      LOAD_X: begin
        s_ready   = x_s_ready;
        x_s_valid = s_valid;
        if (xmem_full) begin
          conv_start_next_s = 1'b1;
          state_next_s      = START;
        end else begin
          state_next_s = LOAD_X;
        end
      end
      START: begin
        state_next_s = RUN;
      end
      RUN: begin
        s_ready   = x_s_ready;
        x_s_valid = s_valid;
        if (conv_done) begin
          state_next_s = CLR;
        end else begin
          state_next_s = RUN;
        end
      end
      CLR: begin
        // Without a loaded filter (e.g. after reset) the filter is fetched regardless of RELOAD_F.
        if (RELOAD_F || !f_loaded_r) begin
          state_next_s = LOAD_F;
        end else begin
          state_next_s = LOAD_X;
        end
      end
      default: begin
        state_next_s = LOAD_F;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= LOAD_F;
      fmem_addr_r  <= {AW{1'b0}};
      conv_start_r <= 1'b0;
      f_loaded_r   <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      fmem_addr_r  <= fmem_addr_next_s;
      conv_start_r <= conv_start_next_s;
      f_loaded_r   <= f_loaded_next_s;
    end
  end

  assign in_run_s = (state_r == RUN);
  assign hs_s     = in_run_s && m_valid && m_ready;
  assign done_s   = in_run_s && conv_done;

  conv_out_counter #(
    .Y_SIZE (Y_SIZE)
  ) u_out_counter (
    .clk   (clk),
    .reset (reset),
    .hs    (hs_s),
    .done  (done_s),
    .clr   (done_s),
    .cnt   (y_cnt_unused_s),
    .err   (y_count_err)
  );

  assign fmem_wr_en = wr_s;
  assign fmem_addr  = fmem_addr_r;
  assign conv_start = conv_start_r;
  assign busy       = !((state_r == LOAD_F) && (fmem_addr_r == {AW{1'b0}}));

endmodule

// File: tb/tb_ctrl_conv_sched.sv
// Bench for ctrl_conv_sched: directed vector table, a reset-in-run sequence and
// randomized traffic against a behavioural model, for RELOAD_F=1 and RELOAD_F=0.
module tb_ctrl_conv_sched;

  localparam int X = 8;
  localparam int F = 3;
  localparam int Y = X - F + 1;

  localparam int P_FILT  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_PULSE = 2;
  localparam int P_OUT   = 3;
  localparam int P_GAP   = 4;

  logic clk = 1'b0;
  logic reset, s_valid, x_s_ready, xmem_full, conv_done, m_valid, m_ready;
  logic s_ready_w [2];
  logic fmem_wr_en_w [2];
  logic [1:0] fmem_addr_w [2];
  logic x_s_valid_w [2];
  logic conv_start_w [2];
  logic busy_w [2];
  logic err_w [2];

  int checks = 0;
  int errors = 0;

  int ph [2];
  int fc [2];
  int yc [2];
  bit er [2];
  bit fl [2];

  typedef struct {
    logic [6:0] in;   // {rst, s_valid, x_s_ready, xmem_full, conv_done, m_valid, m_ready}
    logic [7:0] ex;   // {s_ready, x_s_valid, fmem_wr_en, fmem_addr[1:0], conv_start, busy, y_count_err}
  } vec_t;
  vec_t vt [$];

  always #5 clk = ~clk;

  ctrl_conv_sched #(.X_SIZE(X), .F_SIZE(F), .RELOAD_F(1'b1)) dut1 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_w[1]),
    .fmem_wr_en(fmem_wr_en_w[1]), .fmem_addr(fmem_addr_w[1]), .x_s_valid(x_s_valid_w[1]),
    .x_s_ready(x_s_ready), .xmem_full(xmem_full), .conv_start(conv_start_w[1]),
    .conv_done(conv_done), .m_valid(m_valid), .m_ready(m_ready), .busy(busy_w[1]),
    .y_count_err(err_w[1])
  );

  ctrl_conv_sched #(.X_SIZE(X), .F_SIZE(F), .RELOAD_F(1'b0)) dut0 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_w[0]),
    .fmem_wr_en(fmem_wr_en_w[0]), .fmem_addr(fmem_addr_w[0]), .x_s_valid(x_s_valid_w[0]),
    .x_s_ready(x_s_ready), .xmem_full(xmem_full), .conv_start(conv_start_w[0]),
    .conv_done(conv_done), .m_valid(m_valid), .m_ready(m_ready), .busy(busy_w[0]),
    .y_count_err(err_w[0])
  );

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [reload=%0d] t=%0t: actual %0h expected %0h", name, i, $time, act, exp);
    end
  endtask

  task automatic model_check();
    for (int i = 0; i < 2; i++) begin
      bit e_sr, e_xv, e_wr, e_st, e_busy;
      bit routed;
      routed = (ph[i] == P_WAIT) || (ph[i] == P_OUT);
      e_sr   = (ph[i] == P_FILT) ? 1'b1 : (routed ? x_s_ready : 1'b0);
      e_xv   = routed ? s_valid : 1'b0;
      e_wr   = (ph[i] == P_FILT) && s_valid;
      e_st   = (ph[i] == P_PULSE);
      e_busy = !((ph[i] == P_FILT) && (fc[i] == 0));
      chk("model.s_ready",     i, s_ready_w[i],    e_sr);
      chk("model.x_s_valid",   i, x_s_valid_w[i],  e_xv);
      chk("model.fmem_wr_en",  i, fmem_wr_en_w[i], e_wr);
      chk("model.fmem_addr",   i, fmem_addr_w[i],  fc[i]);
      chk("model.conv_start",  i, conv_start_w[i], e_st);
      chk("model.busy",        i, busy_w[i],       e_busy);
      chk("model.y_count_err", i, err_w[i],        er[i]);
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      int n;
      if (reset) begin
        ph[i] = P_FILT; fc[i] = 0; yc[i] = 0; er[i] = 1'b0; fl[i] = 1'b0;
      end else begin
        case (ph[i])
          P_FILT: if (s_valid) begin
            if (fc[i] == F - 1) begin
              fc[i] = 0; fl[i] = 1'b1; ph[i] = P_WAIT;
            end else begin
              fc[i]++;
            end
          end
          P_WAIT:  if (xmem_full) ph[i] = P_PULSE;
          P_PULSE: ph[i] = P_OUT;
          P_OUT: begin
            n = yc[i] + ((m_valid && m_ready) ? 1 : 0);
            if (n > Y) n = Y;
            if (conv_done) begin
              if (n != Y) er[i] = 1'b1;
              yc[i] = 0;
              ph[i] = P_GAP;
            end else begin
              yc[i] = n;
            end
          end
          P_GAP: ph[i] = ((i == 1) || !fl[i]) ? P_FILT : P_WAIT;
          default: ph[i] = P_FILT;
        endcase
      end
    end
  endtask

  task automatic apply(input bit rst, input bit sv, input bit xr, input bit xf,
                       input bit cd, input bit mv, input bit mr);
    reset = rst; s_valid = sv; x_s_ready = xr; xmem_full = xf;
    conv_done = cd; m_valid = mv; m_ready = mr;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic add(input logic [6:0] in, input logic [7:0] ex);
    vec_t v;
    v.in = in;
    v.ex = ex;
    vt.push_back(v);
  endtask

  initial begin
    // Expected values for the RELOAD_F=1 instance, one row per cycle.
    add(7'b0_0_0_0_1_1_1, 8'b1_0_0_00_0_0_0); // r0  after reset; done/handshake ignored in LOAD_F
    add(7'b0_1_0_0_0_0_0, 8'b1_0_1_00_0_0_0); // r1  filter beat 0
    add(7'b0_1_0_0_0_0_0, 8'b1_0_1_01_0_1_0); // r2  filter beat 1
    add(7'b0_1_0_0_0_0_0, 8'b1_0_1_10_0_1_0); // r3  filter beat 2
    add(7'b0_1_1_0_0_0_0, 8'b1_1_0_00_0_1_0); // r4  4th beat goes to xmem
    add(7'b0_1_0_0_0_0_0, 8'b0_1_0_00_0_1_0); // r5  xmem back-pressure
    add(7'b0_1_1_1_0_0_0, 8'b1_1_0_00_0_1_0); // r6  xmem_full sampled
    add(7'b0_1_1_1_0_0_0, 8'b0_0_0_00_1_1_0); // r7  START: pulse, stream blocked
    add(7'b0_0_1_0_0_1_1, 8'b1_0_0_00_0_1_0); // r8  y=1
    add(7'b0_0_1_0_0_1_0, 8'b1_0_0_00_0_1_0); // r9  no accept
    add(7'b0_0_1_0_0_1_1, 8'b1_0_0_00_0_1_0); // r10 y=2
    add(7'b0_0_1_0_0_1_1, 8'b1_0_0_00_0_1_0); // r11 y=3
    add(7'b0_0_1_0_0_1_1, 8'b1_0_0_00_0_1_0); // r12 y=4
    add(7'b0_0_1_0_0_1_1, 8'b1_0_0_00_0_1_0); // r13 y=5
    add(7'b0_0_1_0_0_1_0, 8'b1_0_0_00_0_1_0); // r14 no accept
    add(7'b0_0_1_0_1_1_1, 8'b1_0_0_00_0_1_0); // r15 6th accept with conv_done
    add(7'b0_1_1_0_0_1_1, 8'b0_0_0_00_0_1_0); // r16 CLR
    add(7'b0_0_0_0_0_0_0, 8'b1_0_0_00_0_0_0); // r17 back in LOAD_F
    add(7'b0_1_0_0_0_0_0, 8'b1_0_1_00_0_0_0); // r18
    add(7'b0_1_0_0_0_0_0, 8'b1_0_1_01_0_1_0); // r19
    add(7'b0_1_0_0_0_0_0, 8'b1_0_1_10_0_1_0); // r20
    add(7'b0_0_1_1_0_1_1, 8'b1_0_0_00_0_1_0); // r21 full already high on entry
    add(7'b0_0_1_1_1_1_1, 8'b0_0_0_00_1_1_0); // r22 START; done ignored
    add(7'b0_0_1_0_0_1_1, 8'b1_0_0_00_0_1_0); // r23 y=1
    add(7'b0_0_1_0_0_1_1, 8'b1_0_0_00_0_1_0); // r24 y=2
    add(7'b0_0_1_0_0_1_1, 8'b1_0_0_00_0_1_0); // r25 y=3
    add(7'b0_0_1_0_0_1_1, 8'b1_0_0_00_0_1_0); // r26 y=4
    add(7'b0_0_1_0_1_1_1, 8'b1_0_0_00_0_1_0); // r27 y=5 at done: short run
    add(7'b0_0_0_0_0_0_0, 8'b0_0_0_00_0_1_1); // r28 CLR, error latched
    add(7'b0_0_0_0_0_0_0, 8'b1_0_0_00_0_0_1); // r29 LOAD_F, error sticky

    reset = 1'b1; s_valid = 1'b0; x_s_ready = 1'b0; xmem_full = 1'b0;
    conv_done = 1'b0; m_valid = 1'b0; m_ready = 1'b0;
    @(posedge clk);
    model_update();
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < vt.size(); k++) begin
      apply(vt[k].in[6], vt[k].in[5], vt[k].in[4], vt[k].in[3], vt[k].in[2], vt[k].in[1], vt[k].in[0]);
      chk($sformatf("vec%0d.s_ready", k),     1, s_ready_w[1],    vt[k].ex[7]);
      chk($sformatf("vec%0d.x_s_valid", k),   1, x_s_valid_w[1],  vt[k].ex[6]);
      chk($sformatf("vec%0d.fmem_wr_en", k),  1, fmem_wr_en_w[1], vt[k].ex[5]);
      chk($sformatf("vec%0d.fmem_addr", k),   1, fmem_addr_w[1],  vt[k].ex[4:3]);
      chk($sformatf("vec%0d.conv_start", k),  1, conv_start_w[1], vt[k].ex[2]);
      chk($sformatf("vec%0d.busy", k),        1, busy_w[1],       vt[k].ex[1]);
      chk($sformatf("vec%0d.y_count_err", k), 1, err_w[1],        vt[k].ex[0]);
      tick();
    end

    // Reset in the middle of a run; the RELOAD_F=0 instance must also reload its filter.
    repeat (3) begin
      apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("seq.start_reload1", 1, conv_start_w[1], 1'b1);
    chk("seq.start_reload0", 0, conv_start_w[0], 1'b1);
    tick();
    repeat (2) begin
      apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
    end
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("seq.err_sticky", 1, err_w[1], 1'b1);
    tick();
    for (int a = 0; a < 3; a++) begin
      apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("seq.after_rst.wr%0d", a),   1, fmem_wr_en_w[1], 1'b1);
      chk($sformatf("seq.after_rst.addr%0d", a), 1, fmem_addr_w[1],  a);
      chk($sformatf("seq.after_rst.wr0_%0d", a), 0, fmem_wr_en_w[0], 1'b1);
      if (a == 0) begin
        chk("seq.after_rst.start", 1, conv_start_w[1], 1'b0);
        chk("seq.after_rst.err",   1, err_w[1],        1'b0);
        chk("seq.after_rst.y_cnt", 1, dut1.y_cnt_unused_s, 0);
      end
      tick();
    end

    // Randomized traffic, both instances checked against the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      apply($urandom_range(0, 299) == 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
            ($urandom % 4) == 0, ($urandom % 9) == 0, $urandom % 2, ($urandom % 4) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
